// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO and per-frame parity / stop-bit framing.
// Paced by an external baud tick; serial output is registered and idles high.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx_busy,
    output logic [CNT_W-1:0]     fifo_count,
    output logic                 tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr;
    logic [PTR_W-1:0]     r_rd;
    logic [CNT_W-1:0]     r_count;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_data;
    logic [BIT_W-1:0]     r_bit;
    logic [1:0]           r_stop;
    logic [1:0]           r_par;
    logic                 r_stop2;
    logic                 r_tx;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_par_en;
    logic w_tx_next;

    assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push   = tx_valid & ~w_full;
    assign w_pop    = (r_state == S_IDLE) & baud_tick & (r_count != '0);
    assign w_par_en = (r_par == 2'b01) | (r_par == 2'b10);

    assign tx_ready   = ~w_full;
    assign tx_busy    = (r_state != S_IDLE);
    assign fifo_count = r_count;
    assign tx         = r_tx;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Line level follows the current state; registering it delays tx one cycle
    // behind the state update so each bit spans tick edge to tick edge.
    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_data[r_bit];
            S_PARITY: w_tx_next = (r_par == 2'b10) ? ~^r_data : ^r_data;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_bit   <= '0;
            r_stop  <= '0;
            r_par   <= '0;
            r_stop2 <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_data  <= r_mem[r_rd];
                        r_par   <= cfg_parity;
                        r_stop2 <= cfg_stop2;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (r_bit == BIT_W'(DATA_BITS - 1)) begin
                            if (w_par_en) begin
                                r_state <= S_PARITY;
                            end else begin
                                r_stop  <= r_stop2 ? 2'd2 : 2'd1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tick) begin
                        r_stop  <= r_stop2 ? 2'd2 : 2'd1;
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        r_stop <= r_stop - 2'd1;
                        if (r_stop == 2'd1) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DATA_BITS=8, FIFO_DEPTH=16).
// Baud tick every 16 clocks; line sampled mid-bit on the falling clock edge.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic [4:0] fifo_count;
    logic       tx;
    logic       baud_tick;

    logic       tick_en = 1'b0;
    logic       gen_tick = 1'b0;
    logic       man_tick = 1'b0;
    int         div = 0;
    int         busy_total = 0;
    int         tests = 0;
    int         fails = 0;

    assign baud_tick = gen_tick | man_tick;

    uart_tx_fifo #(
        .DATA_BITS (8),
        .FIFO_DEPTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .cfg_parity(cfg_parity),
        .cfg_stop2 (cfg_stop2),
        .tx_busy   (tx_busy),
        .fifo_count(fifo_count),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (tick_en) begin
            if (div == 15) begin
                gen_tick = 1'b1;
                div = 0;
            end else begin
                gen_tick = 1'b0;
                div = div + 1;
            end
        end else begin
            gen_tick = 1'b0;
            div = 0;
        end
    end

    always @(negedge clk) begin
        if (tx_busy === 1'b1) busy_total = busy_total + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        tick_en = 1'b0;
        tx_valid = 1'b0;
        man_tick = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data = d;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_start(input int limit, output bit ok, output time t);
        int i;
        ok = 1'b0;
        t = 0;
        i = 0;
        while (!ok && i < limit) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ok = 1'b1;
                t = $time;
            end
            i++;
        end
    endtask

    task automatic capture(input int n, output logic [15:0] v);
        v = '0;
        repeat (8) @(negedge clk);
        v[0] = tx;
        for (int i = 1; i < n; i++) begin
            repeat (16) @(negedge clk);
            v[i] = tx;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int i;
        ok = 1'b0;
        i = 0;
        while (!ok && i < 64) begin
            @(negedge clk);
            if (tx_busy === 1'b0) ok = 1'b1;
            i++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++;
        if (tx !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 5'd0) begin
            fails++;
            $display("FAIL reset_state: got tx=%b ready=%b busy=%b count=%0d expected 1 1 0 0",
                     tx, tx_ready, tx_busy, fifo_count);
        end
    endtask

    // One framed byte: checks line bits, busy duration and idle return.
    task automatic run_frame(input string name, input logic [7:0] d, input logic [1:0] par,
                             input logic s2, input int n, input logic [15:0] exp_bits);
        bit ok;
        time t;
        int b0;
        logic [15:0] v;
        cfg_parity = par;
        cfg_stop2 = s2;
        tick_en = 1'b1;
        b0 = busy_total;
        push(d);
        tests++;
        if (fifo_count !== 5'd1) begin
            fails++;
            $display("FAIL %s_count_after_push: got %0d expected 1", name, fifo_count);
        end
        wait_start(200, ok, t);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_start_timeout: got no start bit expected start bit", name);
        end
        capture(n, v);
        tests++;
        if (v !== exp_bits) begin
            fails++;
            $display("FAIL %s_bits: got %h expected %h", name, v, exp_bits);
        end
        wait_idle(ok);
        tests++;
        if (!ok || (busy_total - b0) != n * 16) begin
            fails++;
            $display("FAIL %s_busy_len: got %0d expected %0d", name, busy_total - b0, n * 16);
        end
        tests++;
        if (fifo_count !== 5'd0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL %s_after: got count=%0d tx=%b expected 0 1", name, fifo_count, tx);
        end
    endtask

    task automatic test_8n1();
        do_reset();
        tests++;
        if (fifo_count !== 5'd0) begin
            fails++;
            $display("FAIL 8n1_count_before: got %0d expected 0", fifo_count);
        end
        run_frame("8n1", 8'hA5, 2'b00, 1'b0, 10, 16'h034A);
    endtask

    task automatic test_8e2();
        run_frame("8e2", 8'h07, 2'b01, 1'b1, 12, 16'h0E0E);
    endtask

    task automatic test_odd();
        run_frame("8o2", 8'h07, 2'b10, 1'b1, 12, 16'h0C0E);
    endtask

    task automatic test_fill_overflow();
        bit ok;
        time t;
        time tprev;
        logic [15:0] v;
        logic [15:0] e;
        do_reset();
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i));
        tests++;
        if (fifo_count !== 5'd16 || tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL fill_full: got count=%0d ready=%b expected 16 0", fifo_count, tx_ready);
        end
        push(8'hAA);
        tests++;
        if (fifo_count !== 5'd16) begin
            fails++;
            $display("FAIL fill_overflow_drop: got %0d expected 16", fifo_count);
        end
        tick_en = 1'b1;
        tprev = 0;
        for (int k = 0; k < 16; k++) begin
            wait_start(300, ok, t);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL fill_start_%0d: got no start bit expected start bit", k);
            end
            if (k > 0) begin
                tests++;
                if (t - tprev != 1760) begin
                    fails++;
                    $display("FAIL fill_spacing_%0d: got %0t expected 1760", k, t - tprev);
                end
            end
            tprev = t;
            capture(10, v);
            e = {6'b0, 1'b1, 8'(k), 1'b0};
            tests++;
            if (v !== e) begin
                fails++;
                $display("FAIL fill_frame_%0d: got %h expected %h", k, v, e);
            end
        end
        wait_start(400, ok, t);
        tests++;
        if (ok || fifo_count !== 5'd0) begin
            fails++;
            $display("FAIL fill_no_extra: got extra_start=%b count=%0d expected 0 0", ok, fifo_count);
        end
    endtask

    task automatic test_cfg_change();
        bit ok;
        time t;
        logic [15:0] v;
        do_reset();
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        tick_en = 1'b1;
        push(8'h55);
        push(8'h31);
        wait_start(200, ok, t);
        cfg_parity = 2'b01;
        capture(10, v);
        tests++;
        if (!ok || v !== 16'h02AA) begin
            fails++;
            $display("FAIL cfg_cur_frame: got %h expected 02aa", v);
        end
        wait_start(200, ok, t);
        capture(11, v);
        tests++;
        if (!ok || v !== 16'h0662) begin
            fails++;
            $display("FAIL cfg_next_frame: got %h expected 0662", v);
        end
    endtask

    task automatic test_simul_push_pop();
        do_reset();
        push(8'h01);
        push(8'h02);
        push(8'h03);
        tests++;
        if (fifo_count !== 5'd3) begin
            fails++;
            $display("FAIL simul_pre_count: got %0d expected 3", fifo_count);
        end
        tx_valid = 1'b1;
        tx_data = 8'h04;
        man_tick = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        man_tick = 1'b0;
        tests++;
        if (fifo_count !== 5'd3 || tx_busy !== 1'b1) begin
            fails++;
            $display("FAIL simul_push_pop: got count=%0d busy=%b expected 3 1", fifo_count, tx_busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen_low;
        time t;
        do_reset();
        cfg_parity = 2'b00;
        cfg_stop2 = 1'b0;
        tick_en = 1'b1;
        push(8'h01);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        wait_start(200, ok, t);
        repeat (88) @(negedge clk);
        tests++;
        if (!ok || tx !== 1'b0 || tx_busy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_in_bit4: got tx=%b busy=%b expected 0 1", tx, tx_busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 5'd0) begin
            fails++;
            $display("FAIL rstmid_after: got tx=%b busy=%b count=%0d expected 1 0 0",
                     tx, tx_busy, fifo_count);
        end
        seen_low = 1'b0;
        repeat (640) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) seen_low = 1'b1;
        end
        tests++;
        if (seen_low) begin
            fails++;
            $display("FAIL rstmid_no_frames: got activity=1 expected 0");
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_8e2();
        test_odd();
        test_fill_overflow();
        test_cfg_change();
        test_simul_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO and per-frame runtime framing (parity mode, 1 or 2 stop bits). It sits between the timestamp/report formatter and the serial pin, and is paced by the shared `baud_gen` tick. It accepts bytes from the formatter at full clock rate and serialises them LSB-first. It is the successor to the fixed 8N1 transmitter.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal 5..9.
- `FIFO_DEPTH`, 16: transmit FIFO entries; power of two, at least 2.
- `CNT_W`, `$clog2(FIFO_DEPTH+1)`: localparam, width of `fifo_count`.

- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `baud_tick`  in  1  one-cycle enable at the bit rate, from `baud_gen`.
- `tx_valid`  in  1  write request.
- `tx_data`  in  DATA_BITS  byte to enqueue.
- `tx_ready`  out  1  FIFO not full; a write occurs when `tx_valid && tx_ready`.
- `cfg_parity`  in  2  parity mode: 00 none, 01 even, 10 odd, 11 reserved (treated as none).
- `cfg_stop2`  in  1  0 gives 1 stop bit; 1 gives 2 stop bits.
- `tx_busy`  out  1  high while a frame is in progress (state is not IDLE).
- `fifo_count`  out  CNT_W  current number of FIFO entries, 0..FIFO_DEPTH.
- `tx`  out  1  serial line; idle high; registered.

## Operation
- **FIFO**
  - Synchronous storage with read/write pointers and a registered count.
  - `tx_ready = (fifo_count != FIFO_DEPTH)`, derived from the registered count.
  - When full, a push is refused even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx=1`.
  - On `baud_tick` with count>0: pop the head entry into `data_q`, snapshot `cfg_parity` and `cfg_stop2`, and go to START.
  - With no tick, or with an empty FIFO, stay in IDLE.
- **START**
  - `tx=0`.
  - On `baud_tick`, go to DATA with `bit_q=0`.
- **DATA**
  - `tx=data_q[bit_q]`.
  - On `baud_tick`: if `bit_q==DATA_BITS-1`, go to PARITY when the snapshot parity is 01 or 10, otherwise go to STOP. Else increment `bit_q`.
- **PARITY**
  - Even mode: `tx = ^data_q`. Odd mode: `tx = ~^data_q`.
  - On `baud_tick`, go to STOP.
- **STOP**
  - `tx=1`.
  - `stop_q` is loaded with 1 or 2 from the snapshot on entry.
  - On `baud_tick`, decrement `stop_q`. When it reaches 0, go to IDLE.
- **Frame boundaries**
  - The STOP→IDLE tick cannot also pop.
  - Back-to-back frames are therefore separated by exactly one idle baud period.
- **Configuration**
  - Changes to `cfg_*` mid-frame affect only frames popped afterwards.
- **Reset**
  - Reset mid-frame aborts the frame and flushes the FIFO.

## Timing
- **Output register:** `tx` is a registered output. Its value changes the cycle after the state/bit register update, so every bit lasts exactly one baud period, from tick edge to tick edge.
- **Reset values:**
  - `tx=1`, `tx_ready=1`, `tx_busy=0`, `fifo_count=0`.
  - State is IDLE; pointers, `bit_q` and `stop_q` are 0.
- **Write latency:** an accepted write is reflected in `fifo_count` the next cycle. It is eligible for pop from the following `baud_tick` onward.
- **Start-bit latency:** the start bit begins on the cycle after the popping tick, aligned to the baud grid. There is no partial start bit.
- **`tx_busy` timing:** rises the cycle after the pop tick. Falls the cycle after the final stop tick.
- **Frame length in baud periods:** 1 + DATA_BITS + (parity ? 1 : 0) + (stop2 ? 2 : 1).
- **`baud_tick` contract:** may arrive on any cycle. A tick on the same cycle as a push into an empty FIFO does not pop that byte.
- **Reset exit:** `rst` asserted for one cycle forces `tx=1` on the next cycle, regardless of state.

## Test plan
- **8N1:** reset, write 0xA5 with `cfg_parity=00`, `cfg_stop2=0`, tick every 16 clk.
  - `tx` sequence over 10 bit periods is 0,1,0,1,0,0,1,0,1,1.
  - `tx_busy` is high for exactly 160 clk.
  - `fifo_count` goes 0→1→0.
- **8E2:** write 0x07 with `cfg_parity=01`, `cfg_stop2=1`.
  - Bits are start 0, data 1,1,1,0,0,0,0,0, parity 1, stop 1,1.
  - Frame is 12 baud periods.
- **Odd parity:** repeat the 8E2 byte 0x07 with `cfg_parity=10`; the parity bit is 0.
- **Fill and overflow:** write 16 bytes 0x00..0x0F with no ticks.
  - `fifo_count=16` and `tx_ready=0`.
  - A 17th write is dropped.
  - With ticks enabled, 16 frames are emitted in order 0x00..0x0F.
  - Consecutive start bits are exactly 11 baud periods apart in 8N1.
- **Config change and simultaneous events:**
  - Flip `cfg_parity` mid-frame: the current frame is unchanged and the next frame carries parity.
  - Push and pop on the same cycle at count 3: count stays 3.
- **Reset mid-frame:** assert `rst` during DATA bit 4 with 3 bytes queued.
  - Next cycle: `tx=1`, `tx_busy=0`, `fifo_count=0`.
  - No further frames are emitted.
